// File: rtl/dmem_sram_bridge.sv
// ============================================================================
// dmem_sram_bridge: memory-stage load/store to SRAM-like bus bridge, one
// transaction in flight. Optional DMEM_ADDR_MAP_EN folds kseg0/kseg1 to phys.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        except_flag,
  input  logic        flush,
  input  logic        pipe_advance,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
    map_addr = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
    map_addr = a;
`endif
  endfunction

  always_comb begin
    start   = (state_q == S_IDLE) && mem_valid && !except_flag && !flush;
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          wr_d    = mem_we;
          size_d  = (mem_size == 2'b11) ? 2'b10 : mem_size;
          addr_d  = map_addr(mem_addr);
          wdata_d = mem_wdata;
          wstrb_d = mem_we ? mem_wstrb : 4'b0000;
        end
      end
      S_ADDR: begin
        // An accepted request must still have its response drained.
        if (data_addr_ok) state_d = flush ? S_DISCARD : S_DATA;
        else if (flush)   state_d = S_IDLE;
      end
      S_DATA: begin
        if (data_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!wr_q) rdata_d = data_rdata;
          end
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DONE: begin
        if (flush || pipe_advance) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_ADDR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // The IDLE start term is combinational so the stage freezes in the same
  // cycle the access is presented; reset must still force it low at once.
  assign stall = !rst && (start || (state_q == S_ADDR) ||
                          (state_q == S_DATA) || (state_q == S_DISCARD));

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign mem_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
// ============================================================================
// tb_dmem_sram_bridge: directed vector table plus randomized traffic checked
// against a transaction-level reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_we = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        except_flag = 1'b0, flush = 1'b0, pipe_advance = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  dmem_sram_bridge dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .except_flag(except_flag), .flush(flush),
    .pipe_advance(pipe_advance), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: where the single transaction currently is.
  bit          m_req, m_wait, m_drop, m_done;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  // ctl bit order: rst valid we except flush adv addr_ok data_ok | exp_req exp_stall
  typedef struct {
    logic [9:0]  ctl;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] phys(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a - (a & 32'hE000_0000);
`endif
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_req = 0; m_wait = 0; m_drop = 0; m_done = 0;
    m_wr = 1'b0; m_size = 2'd0; m_addr = 32'h0; m_wdata = 32'h0;
    m_wstrb = 4'h0; m_rdata = 32'h0;
  endtask

  task automatic step(input logic [9:0] ctl, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] rdv,
                      input bit use_exp, input logic [31:0] e_rd);
    bit start;
    {rst, mem_valid, mem_we, except_flag, flush, pipe_advance,
     data_addr_ok, data_data_ok} = ctl[9:2];
    mem_size = sz; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; data_rdata = rdv;
    @(negedge clk);
    if (rst) model_clear();
    start = !(m_req || m_wait || m_drop || m_done) && mem_valid && !except_flag && !flush && !rst;
    chk("data_req", {31'h0, data_req}, {31'h0, m_req});
    chk("stall", {31'h0, stall}, {31'h0, (m_req || m_wait || m_drop || start)});
    chk("mem_rdata", mem_rdata, m_rdata);
    chk("data_wr", {31'h0, data_wr}, {31'h0, m_wr});
    chk("data_size", {30'h0, data_size}, {30'h0, m_size});
    chk("data_addr", data_addr, m_addr);
    chk("data_wdata", data_wdata, m_wdata);
    chk("data_wstrb", {28'h0, data_wstrb}, {28'h0, m_wstrb});
    if (use_exp) begin
      chk("tbl_req", {31'h0, data_req}, {31'h0, ctl[1]});
      chk("tbl_stall", {31'h0, stall}, {31'h0, ctl[0]});
      chk("tbl_rdata", mem_rdata, e_rd);
    end
    if (!rst) begin
      if (start) begin
        m_req = 1; m_wr = mem_we;
        m_size = (mem_size == 2'd3) ? 2'd2 : mem_size;
        m_addr = phys(mem_addr); m_wdata = mem_wdata;
        m_wstrb = mem_we ? mem_wstrb : 4'h0;
      end else if (m_req) begin
        if (data_addr_ok) begin m_req = 0; if (flush) m_drop = 1; else m_wait = 1; end
        else if (flush) m_req = 0;
      end else if (m_wait) begin
        if (data_data_ok) begin
          m_wait = 0;
          if (!flush) begin m_done = 1; if (!m_wr) m_rdata = data_rdata; end
        end else if (flush) begin m_wait = 0; m_drop = 1; end
      end else if (m_drop) begin
        if (data_data_ok) m_drop = 0;
      end else if (m_done) begin
        if (flush || pipe_advance) m_done = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_clear();
    // reset
    tbl.push_back('{10'b1000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0});
    // load word at 0xBFC0_0010, addr_ok first cycle, data_ok two later
    tbl.push_back('{10'b0100000001, 2'd2, 32'hBFC0_0010, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0100001011, 2'd2, 32'hBFC0_0010, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0100000001, 2'd2, 32'hBFC0_0010, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0100000101, 2'd2, 32'hBFC0_0010, 32'h0, 4'h0, 32'h1234_5678, 32'h0});
    tbl.push_back('{10'b0100010000, 2'd2, 32'hBFC0_0010, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    // store half, addr_ok delayed three cycles
    tbl.push_back('{10'b0110000001, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0110000011, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0110000011, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0110001011, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0110000101, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'hFFFF_FFFF, 32'h1234_5678});
    tbl.push_back('{10'b0110010000, 2'd1, 32'h8000_0002, 32'hABCD_0000, 4'hC, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    // exception suppresses the access
    tbl.push_back('{10'b0101000000, 2'd2, 32'h0000_0400, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0101000000, 2'd2, 32'h0000_0400, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    // flush together with addr_ok: response drained four cycles later
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0100101011, 2'd2, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000001, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000001, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000001, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0000000101, 2'd0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'h1234_5678});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    // reset while waiting for data, stale response, then a clean load
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b0100001011, 2'd2, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 32'h1234_5678});
    tbl.push_back('{10'b1100000000, 2'd2, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0000000100, 2'd0, 32'h0, 32'h0, 4'h0, 32'h5555_5555, 32'h0});
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0100001011, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{10'b0100000101, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 32'h0});
    // DONE held three cycles without advance
    tbl.push_back('{10'b0100000000, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100000000, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100000000, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100010000, 2'd2, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    // flush in ADDR without addr_ok
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_0024, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100100011, 2'd2, 32'h0000_0024, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    // flush in DATA coinciding with data_ok
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_0028, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100001011, 2'd2, 32'h0000_0028, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100100101, 2'd2, 32'h0000_0028, 32'h0, 4'h0, 32'h1111_1111, 32'hCAFE_F00D});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    // flush in DONE
    tbl.push_back('{10'b0100000001, 2'd3, 32'h0000_002C, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100001011, 2'd3, 32'h0000_002C, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100000101, 2'd3, 32'h0000_002C, 32'h0, 4'h0, 32'h0BAD_F00D, 32'hCAFE_F00D});
    tbl.push_back('{10'b0100100000, 2'd3, 32'h0000_002C, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    // flush in DATA without data_ok
    tbl.push_back('{10'b0100000001, 2'd2, 32'h0000_0030, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{10'b0100001011, 2'd2, 32'h0000_0030, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{10'b0100100001, 2'd2, 32'h0000_0030, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{10'b0000000001, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});
    tbl.push_back('{10'b0000000101, 2'd0, 32'h0, 32'h0, 4'h0, 32'h7777_7777, 32'h0BAD_F00D});
    tbl.push_back('{10'b0000000000, 2'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D});

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].ctl, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].ws, tbl[i].rd, 1'b1, tbl[i].e_rd);

    for (int i = 0; i < 3000; i++) begin
      logic [9:0] ctl;
      ctl = {($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 10),
             ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 40), 2'b00};
      step(ctl, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port mem_valid, input, 1: memory stage holds a load/store instruction.
REQ-004 SHALL have port mem_we, input, 1: 1=store, 0=load.
REQ-005 SHALL have port mem_size, input, 2: 0=byte, 1=half, 2=word; 3 is treated as word.
REQ-006 SHALL have port mem_addr, input, 32: virtual byte address.
REQ-007 SHALL have port mem_wdata, input, 32: store data, already lane-aligned.
REQ-008 SHALL have port mem_wstrb, input, 4: store byte enables.
REQ-009 SHALL have port except_flag, input, 1: AdEL/AdES or older exception; suppresses the access.
REQ-010 SHALL have port flush, input, 1: pipeline flush (exception/eret).
REQ-011 SHALL have port pipe_advance, input, 1: downstream stage accepts this stage's result.
REQ-012 SHALL have port data_req/data_wr/data_size/data_addr/data_wdata/data_wstrb, output, 1/1/2/32/32/4: SRAM-like request channel.
REQ-013 SHALL have port data_addr_ok, data_data_ok, data_rdata, input, 1/1/32: SRAM-like response signals.
REQ-014 SHALL have port mem_rdata, output, 32: raw loaded word, fed to the load-alignment logic.
REQ-015 SHALL have port stall, output, 1: freezes the memory stage and all older stages.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA, DONE, DISCARD.
REQ-017 In IDLE, SHALL latch we/size/addr/wdata/wstrb and enter ADDR when mem_valid=1, except_flag=0 and flush=0; otherwise SHALL remain in IDLE.
REQ-018 data_req SHALL be 1 only in ADDR; request fields SHALL come from the latched registers and stay stable while data_req=1.
REQ-019 data_wstrb SHALL be 4'b0000 for loads.
REQ-020 In ADDR, data_addr_ok=1 SHALL move to DATA; otherwise the FSM SHALL stay in ADDR.
REQ-021 data_data_ok SHALL be sampled only in DATA and DISCARD; it is ignored in all other states.
REQ-022 In DATA, data_data_ok=1 SHALL capture data_rdata into the mem_rdata register and move to DONE.
REQ-023 mem_rdata SHALL hold its value until the next capture; stores SHALL NOT modify it.
REQ-024 In DONE, pipe_advance=1 SHALL move to IDLE; a new access SHALL start no earlier than the following cycle.
REQ-025 stall SHALL be 1 in ADDR, DATA and DISCARD, and 1 in IDLE when REQ-017 start conditions hold; otherwise 0. stall SHALL be 0 in DONE.
REQ-026 Flush in ADDR with data_addr_ok=0 SHALL go to IDLE and drop data_req next cycle.
REQ-027 Flush in ADDR with data_addr_ok=1, or flush in DATA with data_data_ok=0, SHALL go to DISCARD.
REQ-028 Flush in DATA with data_data_ok=1 SHALL go to IDLE without updating mem_rdata.
REQ-029 Flush in DONE SHALL go to IDLE.
REQ-030 DISCARD SHALL wait for data_data_ok, drop the response (mem_rdata unchanged), then return to IDLE.
REQ-031 Flush in IDLE or DISCARD SHALL have no effect on state.
REQ-032 At most one transaction SHALL be outstanding at any time.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, including mid-transaction.
REQ-034 rst=1 SHALL immediately clear data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, mem_rdata and stall to 0.
REQ-035 A response arriving after reset SHALL be ignored.

Configuration
REQ-036 With macro DMEM_ADDR_MAP_EN defined, a latched address with addr[31:30]=2'b10 (kseg0/kseg1) SHALL drive data_addr={3'b000, addr[28:0]}; all other addresses pass unchanged.
REQ-037 Without DMEM_ADDR_MAP_EN, data_addr SHALL equal the latched address unmodified.

Verification
REQ-038 Load word 0xBFC0_0010, addr_ok on 1st ADDR cycle, data_ok 2 cycles later with 0x1234_5678 -> data_addr=0x1FC0_0010 (macro on) or 0xBFC0_0010 (macro off); mem_rdata=0x1234_5678; stall 0 in DONE.
REQ-039 Store half at 0x8000_0002, wdata 0xABCD_0000, wstrb 4'b1100, addr_ok delayed 3 cycles -> data_req held for 3 cycles with stable fields; data_wr=1, data_size=1; mem_rdata unchanged.
REQ-040 mem_valid=1 with except_flag=1 -> no data_req; stall=0; FSM stays IDLE.
REQ-041 Flush in same cycle as addr_ok, data_ok 4 cycles later with 0xDEAD_BEEF -> DISCARD with stall=1; mem_rdata unchanged; IDLE the cycle after data_ok.
REQ-042 rst asserted while in DATA -> all outputs 0 in same cycle; later data_ok ignored; next load completes normally.
REQ-043 DONE held 3 cycles with pipe_advance=0 -> stall=0 and mem_rdata stable throughout; no new data_req until after pipe_advance.
